// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package rr_arb8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : rr_arb8_pkg

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arb8_if;
    import rr_arb8_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    // Requester side drives requests and observes the grant.
    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    // Arbiter side observes requests and drives the grant.
    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface : rr_arb8_if

// File: rtl/dec3x8.sv
// 3-to-8 line decoder; x is the MSB, z the LSB. Exactly one output is high.
module dec3x8 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7
);

    assign d0 = ~x & ~y & ~z;
    assign d1 = ~x & ~y &  z;
    assign d2 = ~x &  y & ~z;
    assign d3 = ~x &  y &  z;
    assign d4 =  x & ~y & ~z;
    assign d5 =  x & ~y &  z;
    assign d6 =  x &  y & ~z;
    assign d7 =  x &  y &  z;

endmodule : dec3x8

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with grant hold and forced pre-emption.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant; pick next requester starting from ptr
// ST_GRANT | gnt_idx owns the resource until it drops or is pre-empted
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    rr_arb8_if.slave    arb
);

    if (HOLD_MAX < 1 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("rr_arb8: HOLD_MAX must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_MAX - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [CNT_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0] idx_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_drop;
    logic               others_wait;
    logic               preempt;

    // First set request at or after p, wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = p + IDX_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    dec3x8 u_dec (
        .x  (gnt_idx[2]),
        .y  (gnt_idx[1]),
        .z  (gnt_idx[0]),
        .d0 (idx_onehot[0]),
        .d1 (idx_onehot[1]),
        .d2 (idx_onehot[2]),
        .d3 (idx_onehot[3]),
        .d4 (idx_onehot[4]),
        .d5 (idx_onehot[5]),
        .d6 (idx_onehot[6]),
        .d7 (idx_onehot[7])
    );

    // Arbitration decisions derived from the current request vector.
    always_comb begin
        pick_idx    = rr_pick(arb.req, ptr);
        owner_drop  = ~|(arb.req & idx_onehot);
        others_wait = |(arb.req & ~idx_onehot);
        preempt     = (hold_cnt == HOLD_PRE) && others_wait;
    end

    // Grant FSM: owns state, pointer, winner index and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|arb.req) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release and pre-emption take the same exit path.
                    if (owner_drop || preempt) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end else if (hold_cnt != HOLD_TOP) begin
                        hold_cnt  <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    // Grant outputs: decoded winner gated by the valid flag.
    always_comb begin
        arb.gnt       = idx_onehot & {NUM_REQ{gnt_valid}};
        arb.gnt_idx   = gnt_idx;
        arb.gnt_valid = gnt_valid;
    end

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8 (HOLD_MAX=3): directed request patterns push
// expected grants; a monitor pops one entry per grant and checks index,
// grant length and idle gap, plus the gnt/gnt_idx relation every cycle.
module tb_rr_arb8;
    import rr_arb8_pkg::*;

    typedef struct {
        logic [2:0] idx;
        int         len;   // expected grant cycles, 0 = not checked
        int         gap;   // expected idle cycles before, 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arb8_if arb ();

    rr_arb8 #(.HOLD_MAX(3), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] idx, input int len, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: pops expectations when a grant appears.
    initial begin : monitor
        exp_t cur;
        bit   has_cur;
        bit   prev_valid;
        int   run_len;
        int   gap_len;
        logic [7:0] exp_gnt;
        has_cur    = 1'b0;
        prev_valid = 1'b0;
        run_len    = 0;
        gap_len    = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_gnt = arb.gnt_valid ? (8'h01 << arb.gnt_idx) : 8'h00;
                check("gnt_vs_idx", arb.gnt, exp_gnt);
                if (arb.gnt_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        has_cur = 1'b0;
                        $display("FAIL unexpected_grant: got idx %0d expected no grant at %0t",
                                 arb.gnt_idx, $time);
                    end else begin
                        cur     = sb.pop_front();
                        has_cur = 1'b1;
                        check("grant_idx", arb.gnt_idx, cur.idx);
                        if (cur.gap != 0) check("gap_len", gap_len, cur.gap);
                    end
                    run_len = 1;
                end else if (arb.gnt_valid) begin
                    run_len++;
                    if (has_cur) check("idx_stable", arb.gnt_idx, cur.idx);
                end else begin
                    if (prev_valid && has_cur && cur.len != 0)
                        check("grant_len", run_len, cur.len);
                    gap_len = prev_valid ? 1 : gap_len + 1;
                end
                prev_valid = arb.gnt_valid;
            end
        end
    end

    // Directed stimulus.
    initial begin : stimulus
        arb.req = 8'hFF;
        rst     = 1'b1;
        tick(2);
        mon_en = 1'b1;
        check("rst_gnt",   arb.gnt, 8'h00);
        check("rst_valid", arb.gnt_valid, 1'b0);
        check("rst_idx",   arb.gnt_idx, 3'd0);
        check("rst_ptr",   dut.ptr, 3'd0);

        // Full rotation with all requesting: 0..7 then 0, 3 cycles each.
        rst = 1'b0;
        for (int i = 0; i < 9; i++)
            push(3'(i % 8), 3, (i == 0) ? 0 : 1);
        tick(1);
        check("first_gnt", arb.gnt, 8'h01);
        check("first_idx", arb.gnt_idx, 3'd0);
        tick(34);
        arb.req = 8'h00;
        tick(3);
        check("rot_ptr", dut.ptr, 3'd1);

        // Single requester from idle, then drop.
        arb.req = 8'h20;
        push(3'd5, 1, 0);
        tick(1);
        check("r5_gnt", arb.gnt, 8'h20);
        check("r5_idx", arb.gnt_idx, 3'd5);
        arb.req = 8'h00;
        tick(1);
        check("r5_drop_gnt", arb.gnt, 8'h00);
        check("r5_drop_valid", arb.gnt_valid, 1'b0);
        check("r5_last_idx", arb.gnt_idx, 3'd5);
        check("r5_ptr", dut.ptr, 3'd6);

        // Wrap: grant 6 leaves ptr=7, then 0x41 serves 0 before 6.
        arb.req = 8'h40;
        push(3'd6, 1, 0);
        tick(1);
        arb.req = 8'h00;
        tick(1);
        check("wrap_ptr7", dut.ptr, 3'd7);
        arb.req = 8'h41;
        push(3'd0, 3, 0);
        push(3'd6, 3, 1);
        tick(5);
        arb.req = 8'h40;
        tick(2);
        arb.req = 8'h00;
        tick(2);
        check("wrap_ptr_end", dut.ptr, 3'd7);

        // Lone requester holds for 40 cycles; counter saturates.
        arb.req = 8'h08;
        push(3'd3, 40, 0);
        tick(40);
        check("lone_gnt", arb.gnt, 8'h08);
        check("lone_hold", dut.hold_cnt, 2'd3);
        arb.req = 8'h00;
        tick(2);

        // Reset in the middle of a grant to requester 4.
        arb.req = 8'h10;
        push(3'd4, 1, 0);
        tick(1);
        check("pre_rst_idx", arb.gnt_idx, 3'd4);
        check("pre_rst_valid", arb.gnt_valid, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_gnt", arb.gnt, 8'h00);
        check("mid_rst_valid", arb.gnt_valid, 1'b0);
        check("mid_rst_ptr", dut.ptr, 3'd0);
        check("mid_rst_hold", dut.hold_cnt, 2'd0);
        rst = 1'b0;
        arb.req = 8'h28;
        push(3'd3, 1, 0);
        tick(1);
        check("post_rst_idx", arb.gnt_idx, 3'd3);
        arb.req = 8'h00;
        tick(3);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rr_arb8
